// File: rtl/key_debounce_fsm.sv
// Tick-sampled key debouncer with press/release pulses and optional long-press pulse.
// Define KEY_LONGPRESS_EN to build the hold counter and key_long; otherwise key_long is tied low.
module key_debounce_fsm #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned TICK_HZ      = 1000,
    parameter int unsigned STABLE_TICKS = 20,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter bit          ACTIVE_HIGH  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic tick,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DIV        = CLK_HZ / TICK_HZ;
    localparam int unsigned DIV_W      = $clog2(DIV) + 1;
    localparam int unsigned SCNT_W     = $clog2(STABLE_TICKS) + 1;
    localparam logic        IDLE_LEVEL = ACTIVE_HIGH ? 1'b0 : 1'b1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_TICKS - 1);

    if (DIV < 2) begin : g_div_check
        $error("key_debounce_fsm: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (STABLE_TICKS < 2) begin : g_stable_check
        $error("key_debounce_fsm: STABLE_TICKS must be at least 2");
    end
    if (LONG_TICKS <= STABLE_TICKS) begin : g_long_check
        $error("key_debounce_fsm: LONG_TICKS must exceed STABLE_TICKS");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [SCNT_W-1:0]  scnt, scnt_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic               sync1, sync2;
    logic               act;
    logic               level_nxt, press_nxt, release_nxt;

    // Synchronizer flops idle at the released pin level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    always_comb act = sync2 ^ !ACTIVE_HIGH;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            scnt        <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            scnt        <= scnt_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        scnt_nxt    = scnt;
        level_nxt   = key_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (act) begin
                        state_nxt = PRESS_WAIT;
                        scnt_nxt  = SCNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!act) begin
                        state_nxt = IDLE;
                        scnt_nxt  = '0;
                    end else if (scnt == SCNT_LAST) begin
                        state_nxt = HELD;
                        scnt_nxt  = '0;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end else begin
                        scnt_nxt = scnt + SCNT_W'(1);
                    end
                end
                HELD: begin
                    if (!act) begin
                        state_nxt = RELEASE_WAIT;
                        scnt_nxt  = SCNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (act) begin
                        state_nxt = HELD;
                        scnt_nxt  = '0;
                    end else if (scnt == SCNT_LAST) begin
                        state_nxt   = IDLE;
                        scnt_nxt    = '0;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        scnt_nxt = scnt + SCNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    scnt_nxt  = '0;
                end
            endcase
        end
    end

`ifdef KEY_LONGPRESS_EN
    localparam int unsigned       HCNT_W    = $clog2(LONG_TICKS) + 1;
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_TICKS);

    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic              long_nxt;

    // hcnt survives release bounces; only a fresh accepted press clears it.
    always_comb begin
        hcnt_nxt = hcnt;
        long_nxt = 1'b0;
        if (press_nxt) begin
            hcnt_nxt = '0;
        end else if (tick && state == HELD && act && hcnt != HCNT_LAST) begin
            hcnt_nxt = hcnt + HCNT_W'(1);
            long_nxt = (hcnt_nxt == HCNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt     <= '0;
            key_long <= 1'b0;
        end else begin
            hcnt     <= hcnt_nxt;
            key_long <= long_nxt;
        end
    end
`else
    always_comb key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Scoreboard bench: an active-high and an active-low instance see complementary pins and must match one run-length model.
module tb_key_debounce_fsm;

    localparam int DIV    = 10;
    localparam int STABLE = 4;
    localparam int LONG   = 8;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic key_in_n;
    logic tick_a, level_a, press_a, release_a, long_a;
    logic tick_b, level_b, press_b, release_b, long_b;

    always #5 clk = ~clk;
    assign key_in_n = ~key_in;

    key_debounce_fsm #(
        .CLK_HZ(1000), .TICK_HZ(100), .STABLE_TICKS(4), .LONG_TICKS(8), .ACTIVE_HIGH(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .key_in(key_in), .tick(tick_a), .key_level(level_a),
        .key_press(press_a), .key_release(release_a), .key_long(long_a)
    );

    key_debounce_fsm #(
        .CLK_HZ(1000), .TICK_HZ(100), .STABLE_TICKS(4), .LONG_TICKS(8), .ACTIVE_HIGH(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .key_in(key_in_n), .tick(tick_b), .key_level(level_b),
        .key_press(press_b), .key_release(release_b), .key_long(long_b)
    );

    ev_t  q_a[$];
    ev_t  q_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   k        = 0;
    bit   seen_reset = 1'b0;
    bit   in_reset   = 1'b1;
    logic m_level    = 1'b0;
    logic exp_tick;
    int   run  = 0;
    int   hold = 0;
    logic p1, p2, smp;

    task automatic check(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, exp);
        end
    endtask

    function automatic void push_ev(input ev_kind_t kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        q_a.push_back(e);
        q_b.push_back(e);
    endfunction

    // Reference: the level flips once STABLE consecutive tick samples disagree with it;
    // held samples with no pending disagreement accumulate toward a long press.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            seen_reset = 1'b1;
            in_reset   = 1'b1;
            k = 0; m_level = 1'b0; run = 0; hold = 0;
            q_a.delete();
            q_b.delete();
        end else begin
            in_reset = 1'b0;
            k++;
            if (k >= DIV + 1 && (k - 1) % DIV == 0) begin
                smp = p2;
                if (!m_level) begin
                    if (smp) begin
                        run++;
                        if (run == STABLE) begin
                            m_level = 1'b1; run = 0; hold = 0;
                            push_ev(EV_PRESS);
                        end
                    end else begin
                        run = 0;
                    end
                end else begin
                    if (!smp) begin
                        run++;
                        if (run == STABLE) begin
                            m_level = 1'b0; run = 0;
                            push_ev(EV_RELEASE);
                        end
                    end else if (run != 0) begin
                        run = 0;
                    end else if (hold < LONG) begin
                        hold++;
`ifdef KEY_LONGPRESS_EN
                        if (hold == LONG) push_ev(EV_LONG);
`endif
                    end
                end
            end
        end
        p2 = p1;
        p1 = key_in;
    end

    task automatic check_dut(input int d, input logic tk, input logic lv,
                             input logic pr, input logic rl, input logic lg);
        string tag;
        ev_t   e;
        logic  ep, er, el;
        tag = (d == 0) ? "hi" : "lo";
        ep = 1'b0; er = 1'b0; el = 1'b0;
        if (d == 0) begin
            while (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
                e = q_a.pop_front();
                if (e.kind == EV_PRESS) ep = 1'b1;
                else if (e.kind == EV_RELEASE) er = 1'b1;
                else el = 1'b1;
            end
        end else begin
            while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
                e = q_b.pop_front();
                if (e.kind == EV_PRESS) ep = 1'b1;
                else if (e.kind == EV_RELEASE) er = 1'b1;
                else el = 1'b1;
            end
        end
        check({tag, "_tick"}, tk, exp_tick);
        check({tag, "_level"}, lv, m_level);
        check({tag, "_press"}, pr, ep);
        check({tag, "_release"}, rl, er);
        check({tag, "_long"}, lg, el);
        check({tag, "_press_release_excl"}, pr & rl, 1'b0);
        check({tag, "_long_release_excl"}, lg & rl, 1'b0);
    endtask

    always @(negedge clk) begin
        if (seen_reset) begin
            exp_tick = !in_reset && k >= DIV && (k % DIV) == 0;
            check_dut(0, tick_a, level_a, press_a, release_a, long_a);
            check_dut(1, tick_b, level_b, press_b, release_b, long_b);
        end
    end

    task automatic hold_key(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b0;
        key_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        // key already held at reset release, then released
        hold_key(1'b1, 100);
        hold_key(1'b0, 100);
        // clean press held long enough for a long press
        hold_key(1'b1, 150);
        // one-tick release glitch, then sustained release
        hold_key(1'b0, 10);
        hold_key(1'b1, 40);
        hold_key(1'b0, 100);
        // bounce every 7 cycles for about 200 cycles
        for (int i = 0; i < 29; i++) hold_key(logic'(i % 2 == 0), 7);
        hold_key(1'b0, 100);
        // reset during debounce, key still held afterwards
        hold_key(1'b1, 25);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hold_key(1'b1, 120);
        // reset while held, then release
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hold_key(1'b0, 80);
        for (int i = 0; i < 60; i++) begin
            hold_key(logic'($urandom_range(0, 1)), int'($urandom_range(1, 70)));
        end
        hold_key(1'b0, 120);
        check("queue_hi_drained", logic'(q_a.size() == 0), 1'b1);
        check("queue_lo_drained", logic'(q_b.size() == 0), 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_fsm.md
Name: key_debounce_fsm

Overview:
- Single-clock, tick-sampled debouncer and press classifier for one EGO1 push-button or slide switch.
- Sits directly upstream of the breathing-LED logic and replaces the divided debounce clock with a clock-enable tick on the 100 MHz system clock.
- Produces:
  - a clean level
  - one-cycle press and release pulses
  - an optional long-press pulse
- The breathing logic uses these outputs for reset and mode control.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 1000, sample rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be >= 2 (elaboration error otherwise).
- STABLE_TICKS, 20, number of consecutive equal samples needed to accept a change; must be >= 2.
- LONG_TICKS, 1000, number of held ticks, counted from the accepted press, that constitute a long press; must be > STABLE_TICKS.
- ACTIVE_HIGH, 1, 1 = pin reads 1 when pressed (EGO1 buttons); 0 = active-low pin.

Ports:
- clk, input, 1, system clock, 100 MHz.
- rst, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- key_in, input, 1, raw asynchronous pin.
- tick, output, 1, one-cycle sample strobe every DIV clocks.
- key_level, output, 1, debounced state, 1 = pressed.
- key_press, output, 1, one-cycle pulse on an accepted press.
- key_release, output, 1, one-cycle pulse on an accepted release.
- key_long, output, 1, one-cycle pulse when a hold reaches LONG_TICKS.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - All outputs 0.
  - Divider, stable and hold counters 0.
  - FSM in IDLE.
  - Both synchronizer flops loaded with the inactive pin level (ACTIVE_HIGH ? 0 : 1).
  - Reset applied mid-operation aborts everything with no pulse.
  - If the key is still held when reset releases, it must pass full debounce (PRESS_WAIT) before key_press fires.
- Synchronizer:
  - Two flops on key_in.
  - act = sync2 XOR !ACTIVE_HIGH.
  - Adds 2 cycles of latency.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - tick = 1 for exactly the one cycle after div_cnt == DIV-1 (registered).
  - First tick occurs DIV cycles after reset release.
- FSM: all state changes happen only in cycles where tick == 1. No state or counter changes in non-tick cycles.
  - IDLE:
    - act = 1 → PRESS_WAIT, scnt = 1.
  - PRESS_WAIT:
    - act = 0 → IDLE, scnt = 0 (glitch rejected, no pulse).
    - act = 1 and scnt == STABLE_TICKS-1 → HELD; key_level = 1; key_press pulses; hcnt = 0.
    - otherwise scnt++.
  - HELD:
    - act = 0 → RELEASE_WAIT, scnt = 1.
    - act = 1 → hcnt++, saturating at LONG_TICKS.
    - key_long pulses in the cycle hcnt transitions to LONG_TICKS; at most once per press.
  - RELEASE_WAIT:
    - act = 1 → HELD, scnt = 0. hcnt keeps its value (a bounce does not restart long-press timing).
    - act = 0 and scnt == STABLE_TICKS-1 → IDLE; key_level = 0; key_release pulses.
    - otherwise scnt++.
- Timing and widths:
  - Pulses last exactly one clk and are asserted in the cycle after the deciding tick.
  - key_level changes in that same cycle.
  - Counter widths are $clog2 of their maximum value plus 1; no wrap-around is possible.
- Simultaneous events:
  - key_press and key_release are never high in the same cycle.
  - key_long and key_release are never high in the same cycle, because release requires leaving HELD first.
- Acceptance latency from a clean pin edge: 2 synchronizer cycles, plus wait to the next tick, plus (STABLE_TICKS-1)·DIV, plus 1.

Optional Feature:
- Macro: KEY_LONGPRESS_EN.
- Defined:
  - hcnt and key_long logic are present as described above.
- Undefined:
  - No hcnt register.
  - key_long is tied to 0.
  - The port is still present.
  - All other behaviour is identical.

Test Plan:
Bench parameters: CLK_HZ = 1000, TICK_HZ = 100 (DIV = 10), STABLE_TICKS = 4, LONG_TICKS = 8, ACTIVE_HIGH = 1.
- Reset: hold rst = 0 for 5 cycles with key_in = 1 → all outputs 0 during reset. After release, tick first fires at cycle 10 and then every 10 cycles; key_press fires only after 4 consecutive active ticks.
- Clean press: key_in 0→1 and held → key_press high for 1 cycle within 2+10+30+1 cycles; key_level = 1 thereafter; no key_release.
- Bounce rejection: key_in toggles every 7 cycles for 200 cycles, then stays 0 → no pulses; key_level stays 0; FSM returns to IDLE.
- Long press (KEY_LONGPRESS_EN defined): hold 150 cycles → exactly one key_long pulse 8 ticks after key_press. Same stimulus with the macro undefined → key_long stays 0.
- Release bounce: while HELD, a 1-tick low glitch → no key_release and hcnt is not reset. A sustained low → key_release after 4 ticks, and key_level = 0 in the same cycle.
- Active-low: ACTIVE_HIGH = 0, key_in idles at 1, driven to 0 and held → key_press fires with the same timing as the clean-press case.
